// File: rtl/aes_round_sched.sv
// Slot scheduler for an iterative AES round pipeline: tracks which slot holds
// which round, steers the stage-0 mux and hands finished packets downstream.
module aes_round_sched #(
   parameter int DEPTH        = 4,
   parameter int NUM_ROUNDS   = 10,
   parameter int SHIFT_PERIOD = 5
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             shift_enable,
   output logic             load_new,
   output logic             recirc,
   output logic             out_capture,
   output logic [3:0]       key_round,
   output logic [DEPTH-1:0] last_round_mask,
   output logic [3:0]       occupancy,
   output logic             pipeline_full,
   output logic             busy
);
   localparam logic [3:0] CNT_LAST = 4'(SHIFT_PERIOD - 1);
   localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS);
   localparam logic [3:0] DEPTH_W  = 4'(DEPTH);

   logic [3:0]       cnt_reg, cnt_next;
   logic             out_valid_reg;
   logic [DEPTH-1:0] v_vec;
   logic [3:0]       rnd_arr [DEPTH];
   logic             retire, stall, entrance_free, at_phase_end;
   logic             slot0_v_next;
   logic [3:0]       slot0_rnd_next;
   logic [3:0]       occ_sum;

   assign retire        = v_vec[DEPTH-1] && (rnd_arr[DEPTH-1] == RND_LAST);
   assign stall         = retire && out_valid_reg && !out_ready;
   assign at_phase_end  = (cnt_reg == CNT_LAST);
   assign shift_enable  = enable && at_phase_end && !stall;
   assign entrance_free = !v_vec[DEPTH-1] || retire;
   assign in_ready      = shift_enable && entrance_free;
   assign load_new      = in_valid && in_ready;
   assign recirc        = shift_enable && v_vec[DEPTH-1] && !retire;
   assign out_capture   = shift_enable && retire;
   assign key_round     = v_vec[DEPTH-1] ? rnd_arr[DEPTH-1] : 4'd0;
   assign out_valid     = out_valid_reg;

   // A stalled retire parks the phase counter on its last value until drained.
   always_comb begin
      cnt_next = cnt_reg;
      if (!enable)
         cnt_next = '0;
      else if (at_phase_end)
         cnt_next = stall ? cnt_reg : '0;
      else
         cnt_next = cnt_reg + 4'd1;
   end

   always_comb begin
      slot0_v_next   = 1'b0;
      slot0_rnd_next = '0;
      if (recirc) begin
         slot0_v_next   = 1'b1;
         slot0_rnd_next = rnd_arr[DEPTH-1] + 4'd1;
      end else if (load_new) begin
         slot0_v_next   = 1'b1;
         slot0_rnd_next = 4'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic       v_in;
         logic [3:0] rnd_in;
         logic       slot_v_reg;
         logic [3:0] slot_rnd_reg;

         if (gi == 0) begin : g_head
            assign v_in   = slot0_v_next;
            assign rnd_in = slot0_rnd_next;
         end else begin : g_body
            assign v_in   = v_vec[gi-1];
            assign rnd_in = rnd_arr[gi-1];
         end

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               slot_v_reg   <= 1'b0;
               slot_rnd_reg <= '0;
            end else if (shift_enable) begin
               slot_v_reg   <= v_in;
               slot_rnd_reg <= rnd_in;
            end
         end

         assign v_vec[gi]           = slot_v_reg;
         assign rnd_arr[gi]         = slot_rnd_reg;
         assign last_round_mask[gi] = slot_v_reg && (slot_rnd_reg == RND_LAST);
      end
   endgenerate

   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < DEPTH; k++)
         occ_sum = occ_sum + {3'b000, v_vec[k]};
   end

   assign occupancy     = occ_sum;
   assign pipeline_full = (occ_sum == DEPTH_W);
   assign busy          = (|v_vec) || out_valid_reg;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         // A capture on the same edge as a take-away keeps the register full.
         if (out_capture)
            out_valid_reg <= 1'b1;
         else if (out_ready)
            out_valid_reg <= 1'b0;
      end
   end
endmodule
